// File: rtl/disp_pkg.sv
// Shared types and constants for the SSD1306-class display sequencer.
package disp_pkg;

   // Main sequencer states
   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LO,
      S_RST_WAIT,
      S_INIT,
      S_ADDR,
      S_PIX,
      S_CHECK,
      S_READY
   } main_state_e;

   // Per-byte handshake with the SPI byte shifter
   typedef enum logic [1:0] {
      B_IDLE,
      B_ACCEPT,
      B_SHIFT
   } byte_state_e;

   // Controller opcodes
   localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
   localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
   localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
   localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

   // Bytes in the column/page address window sent ahead of every frame
   localparam int ADDR_LEN = 6;

   // Address window: full column range, then full page range
   function automatic logic [7:0] addr_win_byte(input logic [2:0] idx,
                                                input logic [7:0] col_end,
                                                input logic [7:0] page_end);
      logic [7:0] b;
      case (idx)
         3'd0:    b = CMD_COL_ADDR;
         3'd1:    b = 8'h00;
         3'd2:    b = col_end;
         3'd3:    b = CMD_PAGE_ADDR;
         3'd4:    b = 8'h00;
         3'd5:    b = page_end;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/disp_init_rom.sv
// Power-up command list for the display controller: display off first,
// display on last, NOP filler if the list is made longer than the table.
module disp_init_rom
   import disp_pkg::*;
#(
   parameter int INIT_LEN = 16,
   localparam int IW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1
)(
   input  logic [IW-1:0] idx_i,
   output logic [7:0]    data_o
);

   // Index to command byte; the final entry is always display-on
   always_comb begin
      // NOTE: data_o gets a value on every path first, so no latch is inferred.
      data_o = 8'hE3;
      if (idx_i == IW'(INIT_LEN - 1)) begin
         data_o = CMD_DISP_ON;
      end else begin
         case (int'(idx_i))
            0:       data_o = CMD_DISP_OFF;
            1:       data_o = 8'hD5;   // clock divide / oscillator
            2:       data_o = 8'h80;
            3:       data_o = 8'hA8;   // multiplex ratio
            4:       data_o = 8'h3F;
            5:       data_o = 8'hD3;   // display offset
            6:       data_o = 8'h00;
            7:       data_o = 8'h40;   // start line 0
            8:       data_o = 8'h8D;   // charge pump
            9:       data_o = 8'h14;
            10:      data_o = 8'h20;   // horizontal addressing mode
            11:      data_o = 8'h00;
            12:      data_o = 8'hA1;   // segment remap
            13:      data_o = 8'hC8;   // COM scan direction
            14:      data_o = 8'hA4;   // display follows RAM
            default: data_o = 8'hE3;   // NOP
         endcase
      end
   end

endmodule

// File: rtl/disp_seq.sv
// Display sequencer: bit-rate strobe, hardware reset pulse, init list,
// then frames of address window plus framebuffer bytes to the SPI shifter.
module disp_seq
   import disp_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 1000,
   parameter int INIT_LEN   = 16,
   parameter int COLS       = 128,
   parameter int PAGES      = 8,
   localparam int NPIX = COLS * PAGES,
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          refresh,
   output logic          busy,
   output logic          frame_done,
   output logic          spi_en,
   output logic          spi_start,
   output logic [7:0]    spi_data,
   input  logic          spi_done,
   output logic          dc,
   output logic          disp_rst_n,
   output logic [AW-1:0] pix_addr,
   input  logic [7:0]    pix_data
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int RC_W  = $clog2(RST_CYCLES + 1);
   localparam int ROM_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
   localparam int IDX_A = (NPIX > INIT_LEN) ? NPIX : INIT_LEN;
   localparam int IDX_N = (IDX_A > ADDR_LEN) ? IDX_A : ADDR_LEN;
   localparam int IDX_W = $clog2(IDX_N);

   logic [DIV_W-1:0] div_q, div_d;
   logic             spi_en_q;

   main_state_e      st_q;
   byte_state_e      bst_q;
   logic [RC_W-1:0]  rcnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] last_idx;
   logic             last_byte;
   logic [ROM_W-1:0] rom_idx;
   logic [7:0]       rom_byte;
   logic [7:0]       next_byte;

   logic             spi_start_q;
   logic [7:0]       spi_data_q;
   logic             dc_q;
   logic             disp_rst_n_q;
   logic             busy_q;
   logic             frame_done_q;
   logic             pend_q;
   logic [AW-1:0]    pix_addr_q;

   assign spi_en     = spi_en_q;
   assign spi_start  = spi_start_q;
   assign spi_data   = spi_data_q;
   assign dc         = dc_q;
   assign disp_rst_n = disp_rst_n_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign pix_addr   = pix_addr_q;

   // Divider next value: counts 0..CLK_DIV-1 and wraps
   always_comb begin
      div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
   end

   // Free-running divider; the strobe is registered from the terminal count
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous here; rst_n only acts on a clk edge.
      if (!rst_n) begin
         div_q    <= '0;
         spi_en_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every register sees pre-edge values.
         div_q    <= div_d;
         spi_en_q <= (div_q == DIV_W'(CLK_DIV - 1));
      end
   end

   assign rom_idx = ROM_W'(idx_q);

   disp_init_rom #(
      .INIT_LEN (INIT_LEN)
   ) u_init_rom (
      .idx_i  (rom_idx),
      .data_o (rom_byte)
   );

   // Byte source and last index for the phase currently being streamed
   always_comb begin
      next_byte = 8'h00;
      last_idx  = IDX_W'(NPIX - 1);
      case (st_q)
         S_INIT: begin
            next_byte = rom_byte;
            last_idx  = IDX_W'(INIT_LEN - 1);
         end
         S_ADDR: begin
            next_byte = addr_win_byte(3'(idx_q), 8'(COLS - 1), 8'(PAGES - 1));
            last_idx  = IDX_W'(ADDR_LEN - 1);
         end
         S_PIX:   next_byte = pix_data;
         default: ;
      endcase
   end

   assign last_byte = (idx_q == last_idx);

   // Main sequencer with embedded byte handshake; all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q         <= S_IDLE;
         bst_q        <= B_IDLE;
         rcnt_q       <= '0;
         idx_q        <= '0;
         spi_start_q  <= 1'b0;
         spi_data_q   <= 8'h00;
         dc_q         <= 1'b0;
         disp_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         pend_q       <= 1'b0;
         pix_addr_q   <= '0;
      end else begin
         frame_done_q <= 1'b0;
         // Any number of refreshes while busy collapse into one pending frame
         if (refresh && st_q != S_IDLE && st_q != S_READY) begin
            pend_q <= 1'b1;
         end

         case (st_q)
            S_IDLE: begin
               if (enable) begin
                  st_q   <= S_RST_LO;
                  busy_q <= 1'b1;
                  rcnt_q <= '0;
               end
            end

            S_RST_LO: begin
               if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                  rcnt_q       <= '0;
                  disp_rst_n_q <= 1'b1;
                  st_q         <= S_RST_WAIT;
               end else begin
                  rcnt_q <= rcnt_q + 1'b1;
               end
            end

            S_RST_WAIT: begin
               if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                  rcnt_q <= '0;
                  idx_q  <= '0;
                  st_q   <= S_INIT;
               end else begin
                  rcnt_q <= rcnt_q + 1'b1;
               end
            end

            S_INIT, S_ADDR, S_PIX: begin
               case (bst_q)
                  B_IDLE: begin
                     // Byte and dc are frozen here until the shifter finishes
                     spi_data_q  <= next_byte;
                     dc_q        <= (st_q == S_PIX);
                     spi_start_q <= 1'b1;
                     bst_q       <= B_ACCEPT;
                     // Prefetch the next pixel so its data is ready long before
                     // this byte completes; wraps to 0 after the last pixel
                     if (st_q == S_PIX) begin
                        pix_addr_q <= last_byte ? '0 : pix_addr_q + 1'b1;
                     end
                  end
                  B_ACCEPT: begin
                     // The shifter samples spi_start on this same strobe
                     if (spi_en_q) begin
                        spi_start_q <= 1'b0;
                        bst_q       <= B_SHIFT;
                     end
                  end
                  B_SHIFT: begin
                     if (spi_en_q && spi_done) begin
                        bst_q <= B_IDLE;
                        if (last_byte) begin
                           idx_q <= '0;
                           case (st_q)
                              S_INIT:  st_q <= S_ADDR;
                              S_ADDR:  st_q <= S_PIX;
                              default: begin
                                 st_q         <= S_CHECK;
                                 frame_done_q <= 1'b1;
                              end
                           endcase
                        end else begin
                           idx_q <= idx_q + 1'b1;
                        end
                     end
                  end
                  default: bst_q <= B_IDLE;
               endcase
            end

            S_CHECK: begin
               pend_q <= 1'b0;
               if (pend_q || enable || refresh) begin
                  st_q <= S_ADDR;
               end else begin
                  st_q   <= S_READY;
                  busy_q <= 1'b0;
               end
            end

            S_READY: begin
               if (enable || refresh) begin
                  st_q   <= S_ADDR;
                  busy_q <= 1'b1;
               end
            end

            default: st_q <= S_IDLE;
         endcase
      end
   end

endmodule
